fft8_frame_scheduler: RTL and testbench

Shares one 8-point FFT engine between NREQ requesters using round-robin arbitration. Each frame is loaded serially into the block: 8 complex samples with a valid/ready handshake. The block then holds the engine inputs stable, pulses the engine start, waits for done with a timeout, and streams the 8 results out serially, tagged with the requester ID. It sits between the sample-producing channels and the fft_8point datapath.

---
 rtl/fft8_frame_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fft8_frame_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_scheduler.sv
// Round-robin scheduler that shares one 8-point FFT engine between NREQ channels.
// The block loads a frame serially, runs the engine with a timeout, and streams out the tagged result bins.
module fft8_frame_scheduler #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16,
    localparam int ID_W   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    output logic [NREQ-1:0]            gnt,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    in_real,
    input  logic signed [WIDTH-1:0]    in_imag,
    output logic                       fft_start,
    output logic [8*WIDTH-1:0]         fft_x_real,
    output logic [8*WIDTH-1:0]         fft_x_imag,
    input  logic [8*(WIDTH+3)-1:0]     fft_y_real,
    input  logic [8*(WIDTH+3)-1:0]     fft_y_imag,
    input  logic                       fft_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH+2:0]    out_real,
    output logic signed [WIDTH+2:0]    out_imag,
    output logic [2:0]                 out_index,
    output logic [ID_W-1:0]            out_id,
    output logic                       out_last,
    output logic                       timeout_err,
    output logic [15:0]                frame_cnt
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD} state_t;
    state_t state, state_nx;

    logic [ID_W-1:0]          rr_ptr, pick;
    logic [ID_W:0]            cand;
    logic                     found;
    logic [2:0]               cnt, out_idx;
    logic [TW-1:0]            timer;
    logic [7:0][WIDTH-1:0]    sbuf_re, sbuf_im;
    logic [7:0][WIDTH+2:0]    res_re, res_im;
    logic                     grant_en, accept, abort, capture, out_hs;

    // Descending scan: the last hit written is the smallest offset from rr_ptr.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
            if (req[cand[ID_W-1:0]]) begin
                pick  = cand[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        in_ready    = 1'b0;
        fft_start   = 1'b0;
        out_valid   = 1'b0;
        timeout_err = 1'b0;
        grant_en    = 1'b0;
        accept      = 1'b0;
        abort       = 1'b0;
        capture     = 1'b0;
        out_hs      = 1'b0;
        unique case (state)
            S_IDLE: if (found) begin
                grant_en = 1'b1;
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (!req[out_id]) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (cnt == 3'd7) state_nx = S_START;
                end
            end
            S_START: begin
                fft_start = 1'b1;
                state_nx  = S_WAIT;
            end
            // done takes priority over the timeout limit in the same cycle
            S_WAIT: if (fft_done) begin
                capture  = 1'b1;
                state_nx = S_UNLOAD;
            end else if (timer == TW'(TIMEOUT - 1)) begin
                timeout_err = 1'b1;
                state_nx    = S_IDLE;
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    out_hs = 1'b1;
                    if (out_idx == 3'd7) state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            timer     <= '0;
            out_idx   <= '0;
            frame_cnt <= '0;
            sbuf_re   <= '0;
            sbuf_im   <= '0;
            res_re    <= '0;
            res_im    <= '0;
        end else begin
            if (grant_en) begin
                gnt    <= NREQ'(1) << pick;
                out_id <= pick;
                rr_ptr <= (pick == ID_W'(NREQ - 1)) ? '0 : pick + ID_W'(1);
                cnt    <= '0;
            end
            if (abort || (accept && cnt == 3'd7)) gnt <= '0;
            if (accept) begin
                sbuf_re[cnt] <= in_real;
                sbuf_im[cnt] <= in_imag;
                cnt          <= cnt + 3'd1;
            end
            if (state == S_START)     timer <= '0;
            else if (state == S_WAIT) timer <= timer + TW'(1);
            if (capture) begin
                res_re  <= fft_y_real;
                res_im  <= fft_y_imag;
                out_idx <= '0;
            end
            if (out_hs) begin
                out_idx <= out_idx + 3'd1;
                if (out_idx == 3'd7) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign fft_x_real = sbuf_re;
    assign fft_x_imag = sbuf_im;
    assign out_real   = res_re[out_idx];
    assign out_imag   = res_im[out_idx];
    assign out_index  = out_idx;
    assign out_last   = out_valid && (out_idx == 3'd7);

endmodule

// File: tb/tb_fft8_frame_scheduler.sv
// Scoreboard bench for fft8_frame_scheduler with a behavioural FFT engine stand-in.
// Stimulus pushes expected bins at issue time; a negedge monitor pops them on each output handshake.
module tb_fft8_frame_scheduler;
    localparam int WIDTH = 16, NREQ = 4, TIMEOUT = 16, ID_W = 2, YW = WIDTH + 3;

    logic clk = 1'b0, rst;
    logic [NREQ-1:0] req, gnt;
    logic in_valid, in_ready, fft_start, fft_done, out_valid, out_ready, out_last, timeout_err;
    logic signed [WIDTH-1:0] in_real, in_imag;
    logic [8*WIDTH-1:0] fft_x_real, fft_x_imag;
    logic [8*YW-1:0] fft_y_real, fft_y_imag;
    logic signed [YW-1:0] out_real, out_imag;
    logic [2:0] out_index;
    logic [ID_W-1:0] out_id;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    fft8_frame_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .fft_start(fft_start), .fft_x_real(fft_x_real), .fft_x_imag(fft_x_imag),
        .fft_y_real(fft_y_real), .fft_y_imag(fft_y_imag), .fft_done(fft_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_id(out_id), .out_last(out_last),
        .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [YW-1:0]   re;
        logic [YW-1:0]   im;
        logic [2:0]      idx;
        logic [ID_W-1:0] id;
        logic            last;
    } rec_t;

    rec_t sb[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int start_cnt = 0, to_cnt = 0, last_start = 0, last_to = 0;
    int eng_delay = 4;
    int bp_mode = 0, bp_ph = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [YW-1:0] sx(input logic [WIDTH-1:0] a);
        return {{3{a[WIDTH-1]}}, a};
    endfunction

    // Engine stand-in: bin k = (x[k] + x[7-k], 2-free imag x[k] - k); junk on fft_y when not done.
    initial begin
        fft_done   = 1'b0;
        fft_y_real = {8{19'h2AAAA}};
        fft_y_imag = {8{19'h15555}};
        forever begin
            @(negedge clk);
            if (fft_start && eng_delay > 0) begin
                repeat (eng_delay) @(posedge clk);
                #1;
                for (int k = 0; k < 8; k++) begin
                    fft_y_real[k*YW +: YW] = sx(fft_x_real[k*WIDTH +: WIDTH]) + sx(fft_x_real[(7-k)*WIDTH +: WIDTH]);
                    fft_y_imag[k*YW +: YW] = sx(fft_x_imag[k*WIDTH +: WIDTH]) - YW'(k);
                end
                fft_done = 1'b1;
                @(posedge clk);
                #1;
                fft_done   = 1'b0;
                fft_y_real = {8{19'h2AAAA}};
                fft_y_imag = {8{19'h15555}};
            end
        end
    end

    // Downstream ready: always 1, or the repeating 1,0,0 pattern.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1) begin
                bp_ph     = (bp_ph + 1) % 3;
                out_ready = (bp_ph == 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    rec_t cur, held, exp_r;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (fft_start)   begin start_cnt++; last_start = cyc; end
            if (timeout_err) begin to_cnt++;    last_to    = cyc; end
            cur = {out_real, out_imag, out_index, out_id, out_last};
            if (prev_stall) chk("stall_hold", {out_valid, cur}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("out_valid_unexpected", out_valid, 1'b0);
                else begin
                    exp_r = sb.pop_front();
                    chk("bin", cur, exp_r);
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = cur;
        end
    end

    task automatic load_frame(input int id, input logic [WIDTH-1:0] b_re, input logic [WIDTH-1:0] b_im,
                              input int im_step, input bit gaps, input int abort_at, input bit expect_out);
        logic [WIDTH-1:0] xr[8], xi[8];
        rec_t r;
        bit got;
        int k;
        for (int i = 0; i < 8; i++) begin
            xr[i] = b_re + WIDTH'(i);
            xi[i] = b_im + WIDTH'(im_step * i);
        end
        if (expect_out) begin
            for (int i = 0; i < 8; i++) begin
                r.re   = sx(xr[i]) + sx(xr[7-i]);
                r.im   = sx(xi[i]) - YW'(i);
                r.idx  = 3'(i);
                r.id   = ID_W'(id);
                r.last = (i == 7);
                sb.push_back(r);
            end
        end
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (gnt != '0) got = 1'b1;
        end
        chk("grant", gnt, NREQ'(1) << id);
        if (!got) return;
        k = 0;
        while (k < 8) begin
            if (k == abort_at) begin
                req[id]  = 1'b0;
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            if (gaps && (k == 2 || k == 5)) begin
                in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_real  = xr[k];
            in_imag  = xi[k];
            chk("in_ready", in_ready, 1'b1);
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        req[id]  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int s0, t0, c0;
    bit hit;

    initial begin
        rst = 1'b1; req = '0; in_valid = 1'b0; in_real = '0; in_imag = '0;
        #2;
        chk("rst_outputs", {gnt, in_ready, fft_start, out_valid, out_last, timeout_err, out_index, out_id, frame_cnt}, 0);
        #10 rst = 1'b0;

        // Single frame (k,0), grant 0, 4-cycle engine
        req[0] = 1'b1;
        s0 = start_cnt;
        load_frame(0, 16'd0, 16'd0, 0, 1'b0, -1, 1'b1);
        c0 = cyc;
        hit = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            @(negedge clk);
            if (out_valid) hit = 1'b1;
        end
        chk("first_out_latency", cyc - c0, 5);
        wait_drain();
        chk("start_pulses", start_cnt - s0, 1);
        chk("frame_cnt_1", frame_cnt, 16'd1);

        // Round-robin from rr_ptr=1: 1,2,3,0 then req=1001 -> 0,3
        req = 4'b1111;
        load_frame(1, 16'd10, 16'd20, 1, 1'b0, -1, 1'b1);
        load_frame(2, 16'd30, 16'd40, 2, 1'b0, -1, 1'b1);
        load_frame(3, 16'd50, 16'd60, 3, 1'b0, -1, 1'b1);
        req[3] = 1'b1;
        load_frame(0, 16'd70, 16'd80, 4, 1'b0, -1, 1'b1);
        load_frame(3, 16'd90, 16'd5, 5, 1'b0, -1, 1'b1);
        wait_drain();
        chk("frame_cnt_rr", frame_cnt, 16'd6);

        // Output backpressure 1,0,0 and input gaps
        bp_mode = 1;
        req[2] = 1'b1;
        load_frame(2, 16'd100, WIDTH'(-50), 7, 1'b1, -1, 1'b1);
        wait_drain();
        bp_mode = 0;
        chk("frame_cnt_bp", frame_cnt, 16'd7);

        // Abort after 5 samples, then a clean frame from the same requester
        req[1] = 1'b1;
        s0 = start_cnt;
        load_frame(1, 16'd200, 16'd300, 1, 1'b0, 5, 1'b0);
        repeat (20) @(negedge clk);
        chk("abort_no_start", start_cnt - s0, 0);
        chk("abort_gnt", gnt, 4'b0000);
        req[1] = 1'b1;
        load_frame(1, 16'h7FF8, 16'h8000, 1, 1'b0, -1, 1'b1);
        wait_drain();
        chk("frame_cnt_abort", frame_cnt, 16'd8);

        // Timeout: engine silent
        eng_delay = 0;
        t0 = to_cnt;
        req[2] = 1'b1;
        load_frame(2, 16'd1, 16'd2, 1, 1'b0, -1, 1'b0);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            #1;
            if (to_cnt > t0) break;
        end
        chk("timeout_seen", to_cnt - t0, 1);
        chk("timeout_dist", last_to - last_start, 16);
        repeat (5) @(negedge clk);
        chk("timeout_single_pulse", to_cnt - t0, 1);
        chk("frame_cnt_timeout", frame_cnt, 16'd8);

        // done in the same cycle as the limit completes the frame
        eng_delay = 16;
        req[2] = 1'b1;
        load_frame(2, 16'd400, 16'd500, 9, 1'b0, -1, 1'b1);
        wait_drain();
        chk("limit_done_no_err", to_cnt - t0, 1);
        chk("frame_cnt_limit", frame_cnt, 16'd9);
        eng_delay = 4;

        // Async reset mid-UNLOAD at bin 3; rr_ptr must restart at 0
        req[1] = 1'b1;
        load_frame(1, 16'd600, 16'd700, 3, 1'b0, -1, 1'b1);
        hit = 1'b0;
        for (int t = 0; t < 60 && !hit; t++) begin
            @(negedge clk);
            if (out_valid && out_index == 3'd3) hit = 1'b1;
        end
        chk("reached_bin3", hit, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {gnt, in_ready, fft_start, out_valid, out_last, timeout_err, out_index, out_id, frame_cnt}, 0);
        chk("rst_mid_data", {out_real, out_imag}, 0);
        chk("rst_mid_fft_x", {|fft_x_real, |fft_x_imag}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req = 4'b1001;
        load_frame(0, 16'd800, 16'd900, 2, 1'b0, -1, 1'b1);
        load_frame(3, 16'd1000, 16'd1100, 6, 1'b0, -1, 1'b1);
        wait_drain();
        chk("frame_cnt_after_rst", frame_cnt, 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
